// File: rtl/mtsp_conv_pkg.sv
// Shared definitions for the MTSP conversion-unit scheduler.
// Holds the conversion op encodings, the DWORD width and the
// {valid, id} tag that travels alongside each conversion.
package mtsp_conv_pkg;

  localparam int DWORD_W = 32;

  localparam logic CONV_OP_FP2INT = 1'b0;
  localparam logic CONV_OP_INT2FP = 1'b1;

  // Wide enough for the largest supported requester count (8).
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } conv_tag_t;

endpackage

// File: rtl/mtsp_conv_rsp_fifo.sv
// First-word-fall-through response FIFO for the conversion scheduler.
// Stores {requester id, result} pairs; the head is visible whenever the
// FIFO is non-empty. Head id/data read as zero while empty so the
// outputs are defined straight out of reset without clearing storage.
module mtsp_conv_rsp_fifo
  import mtsp_conv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ID_W-1:0]    push_id,
  input  logic [DWORD_W-1:0] push_data,
  input  logic               pop,
  output logic               valid,
  output logic [ID_W-1:0]    head_id,
  output logic [DWORD_W-1:0] head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ID_W-1:0]    mem_id   [DEPTH];
  logic [DWORD_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_pop;

  assign valid     = (count != '0);
  assign do_pop    = pop && valid;
  assign head_id   = valid ? mem_id[rd_ptr]   : '0;
  assign head_data = valid ? mem_data[rd_ptr] : '0;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Storage is written on push only; it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]   <= push_id;
      mem_data[wr_ptr] <= push_data;
    end
  end

  // Read/write pointers and occupancy; push and pop may share an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mtsp_conv_sched.sv
// Round-robin scheduler sharing one MTSP FP2INT/INT2FP conversion unit
// between NUM_REQ requesters. Issues at most one conversion per cycle,
// follows each one through the unit's fixed latency with an id tag and
// returns results through a response FIFO. Issue is credit-limited so a
// result can never reach a full FIFO.
// Optional macro MTSP_CONV_SCHED_PERF_EN builds the busy/stall counters;
// without it PERF_BUSY and PERF_STALL are tied to zero.
module mtsp_conv_sched
  import mtsp_conv_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int CONV_LAT = 2,
  parameter int DEPTH    = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [NUM_REQ-1:0]         REQ_VALID,
  input  logic [NUM_REQ-1:0]         REQ_SEL,
  input  logic [NUM_REQ*32-1:0]      REQ_DATA,
  output logic [NUM_REQ-1:0]         REQ_READY,
  output logic                       CONV_EN,
  output logic                       CONV_SEL,
  output logic [31:0]                CONV_DIN,
  input  logic [31:0]                CONV_DOUT,
  output logic                       RSP_VALID,
  output logic [$clog2(NUM_REQ)-1:0] RSP_ID,
  output logic [31:0]                RSP_DATA,
  input  logic                       RSP_READY,
  output logic                       IDLE,
  output logic [31:0]                PERF_BUSY,
  output logic [31:0]                PERF_STALL
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int CRED_W = $clog2(DEPTH + 1);

  logic [ID_W-1:0]   rr_ptr;
  logic [CRED_W-1:0] credits;
  logic              grant_found;
  logic              grant_valid;
  logic [ID_W-1:0]   grant_idx;
  logic              pop;
  conv_tag_t         tag_pipe [CONV_LAT];
  conv_tag_t         new_tag;
  conv_tag_t         tag_out;
  logic              tag_id_unused;

  // Round-robin search starting just after the last winner.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_found && REQ_VALID[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  assign grant_valid = grant_found && (credits != '0);

  // One-hot accept towards the winning requester.
  always_comb begin
    REQ_READY = '0;
    if (grant_valid) begin
      REQ_READY[grant_idx] = 1'b1;
    end
  end

  // Issue registers: SEL/DIN hold their last values when nothing is granted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr   <= ID_W'(NUM_REQ - 1);
      CONV_EN  <= 1'b0;
      CONV_SEL <= 1'b0;
      CONV_DIN <= '0;
    end else begin
      CONV_EN <= grant_valid;
      if (grant_valid) begin
        rr_ptr   <= grant_idx;
        CONV_SEL <= REQ_SEL[grant_idx];
        CONV_DIN <= REQ_DATA[int'(grant_idx)*DWORD_W +: DWORD_W];
      end
    end
  end

  always_comb begin
    new_tag       = '0;
    new_tag.valid = grant_valid;
    new_tag.id    = TAG_ID_W'(grant_idx);
  end

  // Tag shift register; the last stage lines up with CONV_DOUT being valid.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < CONV_LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= new_tag;
      for (int i = 1; i < CONV_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign tag_out       = tag_pipe[CONV_LAT-1];
  assign tag_id_unused = ^tag_out.id;
  assign pop           = RSP_VALID && RSP_READY;

  // Credits count free FIFO slots not yet promised to an in-flight op.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      credits <= CRED_W'(DEPTH);
    end else begin
      case ({grant_valid, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  mtsp_conv_rsp_fifo #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W)
  ) u_rsp_fifo (
    .clk       (CLK),
    .rst_n     (nRST),
    .push      (tag_out.valid),
    .push_id   (tag_out.id[ID_W-1:0]),
    .push_data (CONV_DOUT),
    .pop       (pop),
    .valid     (RSP_VALID),
    .head_id   (RSP_ID),
    .head_data (RSP_DATA)
  );

  assign IDLE = (credits == CRED_W'(DEPTH)) && !CONV_EN;

`ifdef MTSP_CONV_SCHED_PERF_EN
  logic [31:0] perf_busy;
  logic [31:0] perf_stall;

  // Issue cycles and cycles where demand was blocked by zero credits.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if (grant_valid) begin
        perf_busy <= perf_busy + 32'd1;
      end
      if (|REQ_VALID && (credits == '0)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end

  assign PERF_BUSY  = perf_busy;
  assign PERF_STALL = perf_stall;
`else
  assign PERF_BUSY  = '0;
  assign PERF_STALL = '0;
`endif

endmodule

// File: doc/mtsp_conv_sched.md
Name: mtsp_conv_sched

Overview:
Round-robin scheduler that shares the single MTSP conversion unit (FP2INT / INT2FP) between NUM_REQ requesters, such as thread slots or a host-side preload path.
- Accepts valid/ready requests and issues at most one conversion per cycle into the unit's phase #0 slot.
- Tracks requester IDs through the unit's fixed pipeline and returns results, tagged, through a response FIFO.
- Credit-based issue guarantees a result never arrives at a full FIFO, so the conv unit needs no backpressure.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CONV_LAT, 2, edges from conv input registers updating to CONV_DOUT valid
DEPTH, 4, response FIFO entries; also total credit count (>= 2)

Ports:
CLK  in  1  main clock
nRST  in  1  asynchronous reset, active low
REQ_VALID  in  NUM_REQ  per-requester request valid
REQ_SEL  in  NUM_REQ  per-requester op: 0 = FP2INT, 1 = INT2FP
REQ_DATA  in  NUM_REQ*32  per-requester source DWORD
REQ_READY  out  NUM_REQ  per-requester accept (one-hot or zero)
CONV_EN  out  1  conv micro-op enable (registered)
CONV_SEL  out  1  conv op select (registered)
CONV_DIN  out  32  conv source DWORD (registered)
CONV_DOUT  in  32  conv result
RSP_VALID  out  1  response FIFO not empty
RSP_ID  out  $clog2(NUM_REQ)  requester index of the head response
RSP_DATA  out  32  head result
RSP_READY  in  1  consumer pop
IDLE  out  1  no conversion in flight and FIFO empty
PERF_BUSY  out  32  issue-cycle counter (see Optional Feature)
PERF_STALL  out  32  credit-stall counter (see Optional Feature)

Behaviour:
- Clocking: single clock CLK; asynchronous active-low reset nRST.
- Reset values:
  - REQ_READY, CONV_EN, CONV_SEL, CONV_DIN, RSP_VALID = 0; RSP_ID/RSP_DATA = 0 (FIFO storage need not be reset).
  - IDLE = 1; credits = DEPTH; RR pointer = NUM_REQ-1, so requester 0 wins first; perf counters = 0.
- Arbitration (combinational):
  - Search REQ_VALID starting at pointer+1, with modulo wrap.
  - Grant the first set bit only when credits > 0; REQ_READY = one-hot grant.
  - READY may depend on VALID. Requesters hold VALID/SEL/DATA stable until READY; no requester may wait more than NUM_REQ-1 grants.
- Grant edge:
  - Pointer <= granted index.
  - CONV_EN <= 1; CONV_SEL/CONV_DIN <= granted SEL/DATA.
  - Tag pipe entry <= {1, id}.
  - With no grant: CONV_EN <= 0 and CONV_SEL/CONV_DIN hold their previous values.
- Tag pipe:
  - CONV_LAT-deep shift register of {valid, id}, aligned so the tag exits on the cycle CONV_DOUT is valid.
  - On that cycle, the FIFO pushes {id, CONV_DOUT} at the next edge.
  - Grant-to-RSP_VALID latency = CONV_LAT+1 cycles minimum (3 at default).
- Credits:
  - Grant decrements, pop (RSP_VALID & RSP_READY) increments; both in the same edge leaves the count unchanged.
  - Credits = DEPTH - (in-flight + FIFO occupancy), always.
  - Push into a full FIFO is unreachable; bench asserts it never occurs.
- FIFO: first-word-fall-through.
  - Push and pop in the same cycle allowed, including at full and at empty-with-push (RSP_VALID rises next cycle, no bypass).
  - RSP_VALID, RSP_ID and RSP_DATA stay stable while RSP_READY = 0.
  - Pointers wrap modulo DEPTH.
- IDLE = (credits == DEPTH) & ~CONV_EN.
- Reset mid-operation: all in-flight tags and FIFO contents are discarded and credits restored; results the conv unit emits after reset are ignored because the tags are invalid.

Optional Feature:
Macro: MTSP_CONV_SCHED_PERF_EN.
- Defined:
  - PERF_BUSY increments on every grant edge.
  - PERF_STALL increments on every cycle where |REQ_VALID and credits == 0.
  - Both are 32-bit and wrap at 2^32.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package mtsp_conv_pkg: CONV_OP_FP2INT = 1'b0 and CONV_OP_INT2FP = 1'b1 constants, DWORD width 32, typedef for the {valid, id} tag.
- Sub-module mtsp_conv_rsp_fifo, parameterised DEPTH/ID width, holds {id, data} storage and occupancy count.
- Arbiter, tag pipe and credits stay in the top module.

Test Plan (conv unit replaced by a CONV_LAT model: DOUT = ~DIN, SEL ignored):
- Single request: req 2, DATA 0x0000_0005, RSP_READY = 1.
  -> REQ_READY = 4'b0100 in cycle 0; CONV_EN = 1 in cycle 1; RSP_VALID in cycle 3 with ID 2, DATA 0xFFFF_FFFA; IDLE returns to 1.
- All 4 requesters valid continuously, RSP_READY = 1.
  -> grants in order 0,1,2,3,0,...; one grant per cycle; responses arrive in the same order.
- All valid, RSP_READY = 0.
  -> exactly 4 grants, then REQ_READY = 0 and the FIFO holds 4 entries.
  -> Raise RSP_READY for 1 cycle: exactly one further grant; no FIFO overflow.
- FIFO full with simultaneous pop and grant on the same edge.
  -> credits stay 0 → 1 → 0 as expected; no lost or duplicated responses; IDs remain in order.
- Assert nRST while 2 requests are in flight.
  -> RSP_VALID = 0 and IDLE = 1 immediately; no response appears afterwards.
- With MTSP_CONV_SCHED_PERF_EN, 6 grants plus 3 stalled cycles -> PERF_BUSY = 6, PERF_STALL = 3; without the macro, both read 0.
